// File: rtl/buf2bank_mover_if.sv
// buf2bank_mover_if: request, ping-pong buffer read and bank write bus
// master = mover side, slave = requester/memories; pad_words with BUF2BANK_ZERO_PAD_EN
interface buf2bank_mover_if #(
  parameter int DATA_W    = 128,
  parameter int NUM_BANKS = 52,
  parameter int BUF_AW    = 7,
  parameter int BANK_AW   = 7
);
  logic                 start;
  logic                 abort;
  logic                 buf_sel;
  logic [BUF_AW-1:0]    buf_addr_start;
  logic [BUF_AW-1:0]    buf_addr_end;
  logic [5:0]           bank_first;
  logic [BANK_AW-1:0]   sram_addr_start;
`ifdef BUF2BANK_ZERO_PAD_EN
  logic [3:0]           pad_words;
`endif
  logic                 busy;
  logic                 done;
  logic [1:0]           buf_cen;
  logic                 buf_oen;
  logic [BUF_AW-1:0]    buf_a;
  logic [DATA_W-1:0]    buf_do0;
  logic [DATA_W-1:0]    buf_do1;
  logic [NUM_BANKS-1:0] bank_cen;
  logic [NUM_BANKS-1:0] bank_wen;
  logic [BANK_AW-1:0]   bank_a;
  logic [DATA_W-1:0]    bank_di;

  modport master (
    input  start, abort, buf_sel,
    input  buf_addr_start, buf_addr_end,
    input  bank_first, sram_addr_start,
`ifdef BUF2BANK_ZERO_PAD_EN
    input  pad_words,
`endif
    input  buf_do0, buf_do1,
    output busy, done,
    output buf_cen, buf_oen, buf_a,
    output bank_cen, bank_wen,
    output bank_a, bank_di
  );

  modport slave (
    output start, abort, buf_sel,
    output buf_addr_start, buf_addr_end,
    output bank_first, sram_addr_start,
`ifdef BUF2BANK_ZERO_PAD_EN
    output pad_words,
`endif
    output buf_do0, buf_do1,
    input  busy, done,
    input  buf_cen, buf_oen, buf_a,
    input  bank_cen, bank_wen,
    input  bank_a, bank_di
  );
endinterface

// File: rtl/buf2bank_mover.sv
// buf2bank_mover: copies a ping-pong buffer range into rotating SRAM banks.
// Ports: clk, rst (async active-low), bus (buf2bank_mover_if.master).
// Optional BUF2BANK_ZERO_PAD_EN appends pad_words zero words after the data.
module buf2bank_mover #(
  parameter int DATA_W    = 128,
  parameter int NUM_BANKS = 52,
  parameter int BUF_AW    = 7,
  parameter int BANK_AW   = 7
) (
  input logic clk,
  input logic rst,
  buf2bank_mover_if.master bus
);

  typedef enum logic [1:0] {
    IDLE, XFER, DRAIN, DONE
  } state_t;

  localparam logic [6:0] NB   = 7'(NUM_BANKS);
  localparam logic [5:0] LAST = 6'(NUM_BANKS - 1);

  state_t state_q, state_d;

  logic [BUF_AW-1:0]  rd_addr;
  logic [BUF_AW-1:0]  end_q;
  logic               sel_q;
  logic [5:0]         bank_ptr;
  logic [BANK_AW-1:0] row_q;
  logic [3:0]         pad_left;

  logic               wr_valid;
  logic               wr_pad;
  logic [5:0]         wr_bank;
  logic [BANK_AW-1:0] wr_row;

  logic take;
  logic push;
  logic [3:0] pad_in;

`ifdef BUF2BANK_ZERO_PAD_EN
  assign pad_in = bus.pad_words;
`else
  assign pad_in = 4'd0;
`endif

  assign take = (state_q == IDLE) && bus.start && !bus.abort;

  // A pipeline entry is a buffer read in XFER or a zero word in DRAIN.
  assign push = !bus.abort &&
                ((state_q == XFER) ||
                 ((state_q == DRAIN) && (pad_left != 4'd0)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (take) begin
          if (bus.buf_addr_end < bus.buf_addr_start)
            state_d = DONE;
          else
            state_d = XFER;
        end
      end
      XFER: begin
        if (bus.abort)             state_d = IDLE;
        else if (rd_addr == end_q) state_d = DRAIN;
      end
      DRAIN: begin
        if (bus.abort)             state_d = IDLE;
        else if (pad_left == 4'd0) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_addr  <= '0;
      end_q    <= '0;
      sel_q    <= 1'b0;
      bank_ptr <= '0;
      row_q    <= '0;
      pad_left <= '0;
      wr_valid <= 1'b0;
      wr_pad   <= 1'b0;
      wr_bank  <= '0;
      wr_row   <= '0;
    end else begin
      wr_valid <= push;
      wr_pad   <= (state_q == DRAIN);
      if (take) begin
        rd_addr  <= bus.buf_addr_start;
        end_q    <= bus.buf_addr_end;
        sel_q    <= bus.buf_sel;
        row_q    <= bus.sram_addr_start;
        pad_left <= pad_in;
        if ({1'b0, bus.bank_first} >= NB)
          bank_ptr <= '0;
        else
          bank_ptr <= bus.bank_first;
      end
      if (state_q == XFER)
        rd_addr <= rd_addr + 1'b1;
      if (push) begin
        wr_bank <= bank_ptr;
        wr_row  <= row_q;
        if (bank_ptr == LAST) begin
          bank_ptr <= '0;
          row_q    <= row_q + 1'b1;
        end else begin
          bank_ptr <= bank_ptr + 1'b1;
        end
      end
      if (push && (state_q == DRAIN))
        pad_left <= pad_left - 1'b1;
    end
  end

  logic [NUM_BANKS-1:0] wr_oh;

  always_comb begin
    wr_oh        = '0;
    bus.busy     = (state_q != IDLE);
    bus.done     = (state_q == DONE);
    bus.buf_oen  = (state_q == IDLE);
    bus.buf_cen  = 2'b11;
    bus.buf_a    = '0;
    bus.bank_a   = '0;
    bus.bank_di  = '0;
    if (state_q == XFER) begin
      bus.buf_cen[sel_q] = 1'b0;
      bus.buf_a          = rd_addr;
    end
    if (wr_valid) begin
      wr_oh[wr_bank] = 1'b1;
      bus.bank_a     = wr_row;
      if (!wr_pad)
        bus.bank_di = sel_q ? bus.buf_do1 : bus.buf_do0;
    end
    bus.bank_cen = ~wr_oh;
    bus.bank_wen = ~wr_oh;
  end

endmodule

// File: tb/tb_buf2bank_mover.sv
// tb_buf2bank_mover: directed checks of buf2bank_mover
// Buffer memories are modelled; bank writes are logged mid-cycle.
module tb_buf2bank_mover;

  localparam int DW  = 128;
  localparam int NB  = 52;
  localparam int BAW = 7;
  localparam int KAW = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  buf2bank_mover_if #(
    .DATA_W(DW), .NUM_BANKS(NB),
    .BUF_AW(BAW), .BANK_AW(KAW)
  ) bus ();

  buf2bank_mover #(
    .DATA_W(DW), .NUM_BANKS(NB),
    .BUF_AW(BAW), .BANK_AW(KAW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int nasrt = 0;
  int nfail = 0;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    nasrt++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] dat(input logic s,
                                       input int a);
    logic [31:0] w;
    w = (s ? 32'hB000_0000 : 32'hA000_0000) | a;
    return {4{w}};
  endfunction

  // synchronous-read buffer models
  always @(posedge clk) begin
    if (!bus.buf_cen[0])
      bus.buf_do0 <= dat(1'b0, int'(bus.buf_a));
    if (!bus.buf_cen[1])
      bus.buf_do1 <= dat(1'b1, int'(bus.buf_a));
  end

  int wr_n = 0, done_n = 0;
  int cen0_n = 0, cen1_n = 0, cen01_n = 0;
  int lz, lb;
  logic [5:0]   lg_bank [256];
  logic [6:0]   lg_row  [256];
  logic [127:0] lg_dat  [256];

  always @(negedge clk) begin
    if (rst) begin
      if (bus.done) done_n++;
      if (!bus.buf_cen[0]) cen0_n++;
      if (!bus.buf_cen[1]) cen1_n++;
      if (bus.buf_cen == 2'b01) cen01_n++;
      if (bus.bank_cen != {NB{1'b1}}) begin
        lz = 0;
        lb = 0;
        for (int i = 0; i < NB; i++)
          if (!bus.bank_cen[i]) begin
            lz++;
            lb = i;
          end
        chk("onehot_cen", 128'(lz), 128'd1);
        lg_bank[wr_n % 256] = 6'(lb);
        lg_row[wr_n % 256]  = bus.bank_a;
        lg_dat[wr_n % 256]  = bus.bank_di;
        wr_n++;
      end
    end
  end

  task automatic go(input logic s, input int a0,
                    input int a1, input int bf,
                    input int row, input int pad);
    @(negedge clk);
    bus.start           = 1'b1;
    bus.buf_sel         = s;
    bus.buf_addr_start  = 7'(a0);
    bus.buf_addr_end    = 7'(a1);
    bus.bank_first      = 6'(bf);
    bus.sram_addr_start = 7'(row);
`ifdef BUF2BANK_ZERO_PAD_EN
    bus.pad_words       = 4'(pad);
`else
    if (pad != 0) $display("pad ignored");
`endif
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // edges after the start-sample edge until done is high
  task automatic wait_done(output int edges);
    edges = 0;
    while (!bus.done && edges < 200) begin
      @(posedge clk);
      #1 edges++;
    end
  endtask

  task automatic chk_wr(input string tag, input int idx,
                        input int bank, input int row,
                        input logic [127:0] d);
    chk({tag, "_bank"}, 128'(lg_bank[idx % 256]), 128'(bank));
    chk({tag, "_row"},  128'(lg_row[idx % 256]),  128'(row));
    chk({tag, "_data"}, lg_dat[idx % 256], d);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},  128'(bus.busy),     128'd0);
    chk({tag, "_done"},  128'(bus.done),     128'd0);
    chk({tag, "_bcen"},  128'(bus.buf_cen),  128'd3);
    chk({tag, "_boen"},  128'(bus.buf_oen),  128'd1);
    chk({tag, "_kcen"},  128'(bus.bank_cen), 128'({NB{1'b1}}));
    chk({tag, "_kwen"},  128'(bus.bank_wen), 128'({NB{1'b1}}));
  endtask

  int e, b0, d0, c0, c1, c01;

  initial begin
    rst                 = 1'b0;
    bus.start           = 1'b0;
    bus.abort           = 1'b0;
    bus.buf_sel         = 1'b0;
    bus.buf_addr_start  = '0;
    bus.buf_addr_end    = '0;
    bus.bank_first      = '0;
    bus.sram_addr_start = '0;
`ifdef BUF2BANK_ZERO_PAD_EN
    bus.pad_words       = '0;
`endif
    repeat (3) @(negedge clk);
    chk_idle("rst");
    chk("rst_bufa",  128'(bus.buf_a),   128'd0);
    chk("rst_banka", 128'(bus.bank_a),  128'd0);
    chk("rst_bankdi", bus.bank_di,      128'd0);
    rst = 1'b1;
    @(negedge clk);

    // T1: 4 words from buffer 0 into banks 0..3 row 5
    b0 = wr_n;
    c1 = cen1_n;
    go(1'b0, 0, 3, 0, 5, 0);
    chk("t1_busy", 128'(bus.busy),    128'd1);
    chk("t1_oen",  128'(bus.buf_oen), 128'd0);
    wait_done(e);
    chk("t1_done_seen", 128'(bus.done), 128'd1);
    chk("t1_latency",   128'(e),        128'd5);
    @(posedge clk);
    #1 chk("t1_done_pulse", 128'(bus.done), 128'd0);
    chk("t1_busy_end", 128'(bus.busy), 128'd0);
    chk("t1_nwr", 128'(wr_n - b0), 128'd4);
    chk("t1_cen1", 128'(cen1_n - c1), 128'd0);
    for (int k = 0; k < 4; k++)
      chk_wr("t1", b0 + k, k, 5, dat(1'b0, k));

    // T2: bank wrap 50,51 row 5 then 0,1 row 6; start while busy ignored
    b0 = wr_n;
    go(1'b0, 0, 3, 50, 5, 0);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.bank_first = 6'd20;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(e);
    chk("t2_done_seen", 128'(bus.done), 128'd1);
    @(posedge clk);
    #1 chk("t2_nwr", 128'(wr_n - b0), 128'd4);
    chk_wr("t2w0", b0 + 0, 50, 5, dat(1'b0, 0));
    chk_wr("t2w1", b0 + 1, 51, 5, dat(1'b0, 1));
    chk_wr("t2w2", b0 + 2, 0,  6, dat(1'b0, 2));
    chk_wr("t2w3", b0 + 3, 1,  6, dat(1'b0, 3));

    // T3: single word from buffer 1
    b0  = wr_n;
    c0  = cen0_n;
    c1  = cen1_n;
    c01 = cen01_n;
    go(1'b1, 10, 10, 7, 2, 0);
    wait_done(e);
    chk("t3_latency", 128'(e), 128'd2);
    @(posedge clk);
    #1 chk("t3_nwr", 128'(wr_n - b0), 128'd1);
    chk_wr("t3", b0, 7, 2, dat(1'b1, 10));
    chk("t3_cen0", 128'(cen0_n - c0), 128'd0);
    chk("t3_cen1", 128'(cen1_n - c1), 128'd1);
    chk("t3_cen01", 128'(cen01_n - c01), 128'd1);

    // bank_first beyond NUM_BANKS wraps to bank 0
    b0 = wr_n;
    go(1'b0, 0, 0, 60, 3, 0);
    wait_done(e);
    @(posedge clk);
    #1 chk("bf60_nwr", 128'(wr_n - b0), 128'd1);
    chk_wr("bf60", b0, 0, 3, dat(1'b0, 0));

    // T4: abort in the 3rd cycle of a 20-word transfer
    b0 = wr_n;
    d0 = done_n;
    go(1'b0, 0, 19, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1 bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    chk_idle("t4");
    repeat (30) @(posedge clk);
    #1 chk("t4_nwr", 128'(wr_n - b0), 128'd2);
    chk("t4_nodone", 128'(done_n - d0), 128'd0);

    // abort and start together in IDLE
    b0 = wr_n;
    @(negedge clk);
    bus.start          = 1'b1;
    bus.abort          = 1'b1;
    bus.buf_addr_start = 7'd0;
    bus.buf_addr_end   = 7'd3;
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("sa_busy", 128'(bus.busy), 128'd0);
    repeat (8) @(posedge clk);
    #1 chk("sa_nwr", 128'(wr_n - b0), 128'd0);

    // T5: empty range
    b0  = wr_n;
    c0  = cen0_n;
    c1  = cen1_n;
    go(1'b0, 7, 2, 0, 0, 0);
    chk("t5_done", 128'(bus.done), 128'd1);
    @(posedge clk);
    #1 chk("t5_done_pulse", 128'(bus.done), 128'd0);
    chk("t5_nwr", 128'(wr_n - b0), 128'd0);
    chk("t5_cen", 128'((cen0_n - c0) + (cen1_n - c1)), 128'd0);

    // T5b: async reset mid-transfer
    b0 = wr_n;
    go(1'b0, 0, 19, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk_idle("t5r");
    chk("t5r_bufa",   128'(bus.buf_a),  128'd0);
    chk("t5r_banka",  128'(bus.bank_a), 128'd0);
    chk("t5r_bankdi", bus.bank_di,      128'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (25) @(posedge clk);
    #1 chk("t5r_nwr", 128'(wr_n - b0), 128'd1);
    chk("t5r_busy", 128'(bus.busy), 128'd0);

`ifdef BUF2BANK_ZERO_PAD_EN
    // T6: 2 words then 3 zero pads, wrapping from bank 51
    b0 = wr_n;
    go(1'b0, 0, 1, 51, 0, 3);
    wait_done(e);
    chk("t6_latency", 128'(e), 128'd6);
    @(posedge clk);
    #1 chk("t6_nwr", 128'(wr_n - b0), 128'd5);
    chk_wr("t6w0", b0 + 0, 51, 0, dat(1'b0, 0));
    chk_wr("t6w1", b0 + 1, 0,  1, dat(1'b0, 1));
    chk_wr("t6p0", b0 + 2, 1,  1, 128'd0);
    chk_wr("t6p1", b0 + 3, 2,  1, 128'd0);
    chk_wr("t6p2", b0 + 4, 3,  1, 128'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             nasrt, nfail);
    $finish;
  end

endmodule
